mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Pipeline stage directly downstream of the EX-stage ALU in the 19-bit CPU.
- Registers the ALU result (EX_out) with its destination/control fields.
- Performs data-memory loads and stores over a req/ack handshake with variable latency, stalling EX while an access is outstanding.
- Presents one registered writeback record per accepted instruction to the WB stage and the forwarding logic.

Parameters:
DATA_W, 19, datapath width (matches ALU)
ADDR_W, 12, data-memory address width; low ADDR_W bits of the ALU result
RF_AW, 4, register-file index width
TIMEOUT, 16, max cycles waiting for dmem_ack before error abort (>=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  EX presents an instruction
ex_ready  out  1  stage can accept; combinational = (state==IDLE)
ex_alu_out  in  DATA_W  ALU result; the memory address for mem ops
ex_store_data  in  DATA_W  store data (rs2 value)
ex_rd  in  RF_AW  destination register
ex_reg_write  in  1  instruction writes rd
ex_mem_read  in  1  load
ex_mem_write  in  1  store
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1=write, 0=read
dmem_addr  out  ADDR_W  address
dmem_wdata  out  DATA_W  write data
dmem_rdata  in  DATA_W  read data, valid with dmem_ack
dmem_ack  in  1  access complete
wb_valid  out  1  one-cycle pulse: writeback record valid
wb_reg_write  out  1  WB must write wb_data to wb_rd
wb_rd  out  RF_AW  destination register
wb_data  out  DATA_W  ALU result or load data
mem_err  out  1  sticky: access timed out; cleared only by rst

Behaviour:
- Reset: state=IDLE; all outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, mem_err). ex_ready=1 the cycle after reset deasserts.
- Accept = ex_valid & ex_ready. Fields are sampled at the accept edge.
- States: IDLE, ACCESS.
- IDLE, non-mem accept (mem_read=mem_write=0):
  - Next cycle: wb_valid=1, wb_data=ex_alu_out, wb_rd=ex_rd, wb_reg_write=ex_reg_write.
  - Latency 1; throughput one per cycle back-to-back.
- IDLE, mem accept:
  - Latch dmem_addr=ex_alu_out[ADDR_W-1:0], dmem_wdata=ex_store_data, dmem_we=ex_mem_write, plus rd and reg_write.
  - Set dmem_req=1 and go to ACCESS; ex_ready=0 while in ACCESS.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until dmem_ack is sampled high.
  - On ack: dmem_req=0 next cycle and wb_valid=1 next cycle. State returns to IDLE, so ex_ready=1 that cycle.
  - Load result: wb_data=dmem_rdata, wb_reg_write=latched reg_write.
  - Store result: wb_reg_write=0, wb_data=address zero-extended.
  - Load latency = N+1 cycles, where N = cycles from the first req cycle to ack (ack in the first req cycle gives N=1).
- dmem_ack outside ACCESS is ignored.
- Timeout: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack. On reaching TIMEOUT:
  - dmem_req=0, mem_err=1.
  - wb_valid pulses with wb_reg_write=0, wb_data=0.
  - State returns to IDLE.
  - An ack arriving on the timeout cycle itself counts as a normal completion, not a timeout.
- Both ex_mem_read and ex_mem_write set: treated as a store; wb_reg_write forced 0.
- wb_valid is 0 in every cycle that does not follow a completion; wb_rd, wb_data and wb_reg_write hold their last values when wb_valid=0.
- rst during ACCESS: dmem_req=0 at that edge, the in-flight access is dropped, no wb_valid, and a late ack is ignored.
- Width rules: no arithmetic on data; address truncated to ADDR_W bits, never sign-extended.

Decomposition:
- Shared parameter include holds: state encodings (MS_IDLE, MS_ACCESS), DATA_W=19, RF_AW, and the default TIMEOUT.
- No sub-module; the timeout counter and FSM stay inline (about 150 lines).

Test Plan:
- Reset: assert rst 2 cycles -> all outputs 0, ex_ready=1; mem_err stays 0.
- ALU op stream: 3 back-to-back non-mem ops with ex_alu_out=5,7,0x7FFFF and rd=1,2,3 -> wb_valid high 3 consecutive cycles, each 1 cycle after accept, with matching data/rd; ex_ready never drops.
- Load: ex_alu_out=0x01234, rd=4; ack after 3 req cycles with rdata=0x2AAAA -> dmem_addr=0x234, dmem_we=0, ex_ready=0 for 3 cycles; wb_valid next cycle with wb_data=0x2AAAA, wb_rd=4, wb_reg_write=1.
- Store with read+write both set: addr=0x10, data=0x15 -> dmem_we=1, dmem_wdata=0x15; after ack wb_valid=1, wb_reg_write=0.
- Timeout: load with ack never asserted, TIMEOUT=16 -> dmem_req drops after 16 cycles; mem_err=1 and stays 1; wb_valid pulses with wb_reg_write=0; a later ack is ignored.
- Reset mid-access: rst on 2nd ACCESS cycle, then ack -> no wb_valid; dmem_req=0; ex_ready=1 after reset.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and state encoding for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned MS_DATA_W  = 19;
  localparam int unsigned MS_ADDR_W  = 12;
  localparam int unsigned MS_RF_AW   = 4;
  localparam int unsigned MS_TIMEOUT = 16;

  typedef enum logic {
    MS_IDLE   = 1'b0,
    MS_ACCESS = 1'b1
  } ms_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_stage_if #(
  parameter int unsigned DATA_W = mem_stage_pkg::MS_DATA_W,
  parameter int unsigned ADDR_W = mem_stage_pkg::MS_ADDR_W
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: registers ALU results, performs data-memory loads/stores with
// variable-latency handshake and timeout, emits one writeback record per op.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = MS_DATA_W,
  parameter int unsigned ADDR_W  = MS_ADDR_W,
  parameter int unsigned RF_AW   = MS_RF_AW,
  parameter int unsigned TIMEOUT = MS_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RF_AW-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [RF_AW-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  ms_state_t         state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [RF_AW-1:0]  pend_rd;
  logic              pend_reg_write;

  assign ex_ready = (state == MS_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= MS_IDLE;
      wait_cnt        <= '0;
      pend_rd         <= '0;
      pend_reg_write  <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      wb_valid        <= 1'b0;
      wb_reg_write    <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      mem_err         <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (ex_valid) begin
            if (ex_mem_read || ex_mem_write) begin
              // A read+write combination issues as a store (dmem_we wins).
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= ex_mem_write;
              dmem.dmem_addr  <= ex_alu_out[ADDR_W-1:0];
              dmem.dmem_wdata <= ex_store_data;
              pend_rd         <= ex_rd;
              pend_reg_write  <= ex_reg_write;
              wait_cnt        <= '0;
              state           <= MS_ACCESS;
            end else begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_alu_out;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
            end
          end
        end
        MS_ACCESS: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            wb_valid      <= 1'b1;
            wb_rd         <= pend_rd;
            if (dmem.dmem_we) begin
              wb_reg_write <= 1'b0;
              wb_data      <= DATA_W'(dmem.dmem_addr);
            end else begin
              wb_reg_write <= pend_reg_write;
              wb_data      <= dmem.dmem_rdata;
            end
            state <= MS_IDLE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // TIMEOUT-th request cycle without ack: abort with a null record.
            dmem.dmem_req <= 1'b0;
            mem_err       <= 1'b1;
            wb_valid      <= 1'b1;
            wb_rd         <= pend_rd;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            state         <= MS_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table-driven ALU-op vectors plus hand-written
// load/store/timeout/reset sequences against hand-computed expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [18:0] ex_alu_out;
  logic [18:0] ex_store_data;
  logic [3:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [3:0]  wb_rd;
  logic [18:0] wb_data;
  logic        mem_err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  mem_stage_if #(.DATA_W(19), .ADDR_W(12)) dbus ();

  mem_stage #(.DATA_W(19), .ADDR_W(12), .RF_AW(4), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .dmem          (dbus),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [18:0] alu;
    logic [3:0]  rd;
    logic        rw;
    logic        ack;
    logic        e_valid;
    logic [18:0] e_data;
    logic [3:0]  e_rd;
    logic        e_rw;
  } vec_t;

  vec_t vt[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [18:0] alu, input logic [18:0] sd, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw);
    ex_valid      = 1'b1;
    ex_alu_out    = alu;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    step();
    ex_valid      = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
  endtask

  initial begin
    int unsigned cyc;

    vt[0] = '{1'b1, 19'h00005, 4'd1,  1'b1, 1'b0, 1'b1, 19'h00005, 4'd1, 1'b1};
    vt[1] = '{1'b1, 19'h00007, 4'd2,  1'b1, 1'b0, 1'b1, 19'h00007, 4'd2, 1'b1};
    vt[2] = '{1'b1, 19'h7FFFF, 4'd3,  1'b1, 1'b0, 1'b1, 19'h7FFFF, 4'd3, 1'b1};
    vt[3] = '{1'b0, 19'h00123, 4'd9,  1'b1, 1'b1, 1'b0, 19'h7FFFF, 4'd3, 1'b1};
    vt[4] = '{1'b1, 19'h00ABC, 4'd15, 1'b0, 1'b0, 1'b1, 19'h00ABC, 4'd15, 1'b0};
    vt[5] = '{1'b0, 19'h00000, 4'd0,  1'b0, 1'b0, 1'b0, 19'h00ABC, 4'd15, 1'b0};

    rst = 1'b1;
    ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    dbus.dmem_ack = 1'b0; dbus.dmem_rdata = '0;

    // Reset
    step(); step();
    chk("rst_req",   32'(dbus.dmem_req),   0);
    chk("rst_we",    32'(dbus.dmem_we),    0);
    chk("rst_addr",  32'(dbus.dmem_addr),  0);
    chk("rst_wdata", 32'(dbus.dmem_wdata), 0);
    chk("rst_wbv",   32'(wb_valid),        0);
    chk("rst_wbrw",  32'(wb_reg_write),    0);
    chk("rst_wbrd",  32'(wb_rd),           0);
    chk("rst_wbd",   32'(wb_data),         0);
    chk("rst_err",   32'(mem_err),         0);
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(ex_ready), 1);
    chk("rst_err2",  32'(mem_err),  0);

    // ALU op table
    for (int i = 0; i < 6; i++) begin
      ex_valid = vt[i].v; ex_alu_out = vt[i].alu; ex_rd = vt[i].rd;
      ex_reg_write = vt[i].rw; dbus.dmem_ack = vt[i].ack;
      step();
      chk($sformatf("alu%0d_wbv", i),   32'(wb_valid),      32'(vt[i].e_valid));
      chk($sformatf("alu%0d_wbd", i),   32'(wb_data),       32'(vt[i].e_data));
      chk($sformatf("alu%0d_wbrd", i),  32'(wb_rd),         32'(vt[i].e_rd));
      chk($sformatf("alu%0d_wbrw", i),  32'(wb_reg_write),  32'(vt[i].e_rw));
      chk($sformatf("alu%0d_ready", i), 32'(ex_ready),      1);
      chk($sformatf("alu%0d_req", i),   32'(dbus.dmem_req), 0);
    end
    ex_valid = 1'b0; dbus.dmem_ack = 1'b0;

    // Load, ack in 3rd request cycle
    issue(19'h01234, 19'h0, 4'd4, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin dbus.dmem_ack = 1'b1; dbus.dmem_rdata = 19'h2AAAA; end
      chk($sformatf("ld_req%0d", k),   32'(dbus.dmem_req),  1);
      chk($sformatf("ld_addr%0d", k),  32'(dbus.dmem_addr), 32'h234);
      chk($sformatf("ld_we%0d", k),    32'(dbus.dmem_we),   0);
      chk($sformatf("ld_ready%0d", k), 32'(ex_ready),       0);
      chk($sformatf("ld_wbv%0d", k),   32'(wb_valid),       0);
      if (k < 3) step();
    end
    step();
    dbus.dmem_ack = 1'b0;
    chk("ld_wbv",   32'(wb_valid),      1);
    chk("ld_wbd",   32'(wb_data),       32'h2AAAA);
    chk("ld_wbrd",  32'(wb_rd),         4);
    chk("ld_wbrw",  32'(wb_reg_write),  1);
    chk("ld_req",   32'(dbus.dmem_req), 0);
    chk("ld_ready", 32'(ex_ready),      1);
    step();
    chk("ld_wbv_off", 32'(wb_valid), 0);

    // Store with read+write both set, ack in first request cycle
    issue(19'h00010, 19'h00015, 4'd5, 1'b1, 1'b1, 1'b1);
    chk("st_we",    32'(dbus.dmem_we),    1);
    chk("st_wdata", 32'(dbus.dmem_wdata), 32'h15);
    chk("st_addr",  32'(dbus.dmem_addr),  32'h10);
    chk("st_req",   32'(dbus.dmem_req),   1);
    dbus.dmem_ack = 1'b1;
    step();
    dbus.dmem_ack = 1'b0;
    chk("st_wbv",  32'(wb_valid),     1);
    chk("st_wbrw", 32'(wb_reg_write), 0);
    chk("st_wbd",  32'(wb_data),      32'h10);
    chk("st_wbrd", 32'(wb_rd),        5);

    // Ack on the 16th request cycle is a normal completion
    issue(19'h7F0A5, 19'h0, 4'd7, 1'b1, 1'b1, 1'b0);
    repeat (15) step();
    chk("late_req", 32'(dbus.dmem_req), 1);
    dbus.dmem_ack = 1'b1; dbus.dmem_rdata = 19'h01357;
    step();
    dbus.dmem_ack = 1'b0;
    chk("late_wbv",  32'(wb_valid),     1);
    chk("late_wbd",  32'(wb_data),      32'h1357);
    chk("late_wbrw", 32'(wb_reg_write), 1);
    chk("late_err",  32'(mem_err),      0);
    chk("late_addr", 32'(dbus.dmem_addr), 32'h0A5);

    // Timeout: ack never arrives
    issue(19'h00055, 19'h0, 4'd6, 1'b1, 1'b1, 1'b0);
    cyc = 0;
    while (dbus.dmem_req === 1'b1 && cyc < 40) begin
      cyc++;
      step();
    end
    chk("to_cycles", cyc,                 16);
    chk("to_wbv",    32'(wb_valid),       1);
    chk("to_wbrw",   32'(wb_reg_write),   0);
    chk("to_wbd",    32'(wb_data),        0);
    chk("to_err",    32'(mem_err),        1);
    chk("to_ready",  32'(ex_ready),       1);
    dbus.dmem_ack = 1'b1; dbus.dmem_rdata = 19'h12345;
    step();
    dbus.dmem_ack = 1'b0;
    chk("to_ackign_wbv", 32'(wb_valid),       0);
    chk("to_ackign_req", 32'(dbus.dmem_req),  0);
    chk("to_ackign_wbd", 32'(wb_data),        0);
    issue(19'h00321, 19'h0, 4'd8, 1'b1, 1'b0, 1'b0);
    chk("to_after_wbd", 32'(wb_data), 32'h321);
    chk("to_err_stick", 32'(mem_err), 1);

    // Reset in the 2nd access cycle, then a late ack
    issue(19'h00066, 19'h0, 4'd9, 1'b1, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req",  32'(dbus.dmem_req), 0);
    chk("mrst_wbv",  32'(wb_valid),      0);
    chk("mrst_err",  32'(mem_err),       0);
    dbus.dmem_ack = 1'b1; dbus.dmem_rdata = 19'h0BEEF;
    step();
    dbus.dmem_ack = 1'b0;
    chk("mrst_ack_wbv",  32'(wb_valid),      0);
    chk("mrst_ack_req",  32'(dbus.dmem_req), 0);
    chk("mrst_ready",    32'(ex_ready),      1);
    chk("mrst_wbd",      32'(wb_data),       0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
